// File: rtl/fsm_path_sequencer_pkg.sv
// Shared types and timing constants for the branch-FSM path sequencer.
// Each traversal takes TRAV_LEN cycles, and the FSM reset takes SYNC_LAT cycles.
package fsm_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DRV_X,
    ST_DRV_Y,
    ST_CHK,
    ST_DONE
  } seq_state_e;

  typedef enum logic [1:0] {
    PATH_S2_S4   = 2'd0,
    PATH_S1_S4   = 2'd1,
    PATH_S1_S3   = 2'd2,
    PATH_ILLEGAL = 2'd3
  } path_e;

  localparam int TRAV_LEN = 3;
  localparam int SYNC_LAT = 1;

  // Only the s0->s1->s3 path ends in the state where the FSM output is high.
  function automatic logic path_hits(input path_e p);
    return p == PATH_S1_S3;
  endfunction

endpackage

// File: rtl/fsm_path_sequencer_if.sv
// Command and result bundle between a command source and the path sequencer.
// A command is taken when valid meets ready, and the results hold until the next accept.
interface fsm_path_sequencer_if #(
  parameter int CNT_W = 8
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_path;
  logic [CNT_W-1:0] cmd_count;
  logic             done;
  logic [CNT_W-1:0] hit_count;
  logic             mismatch;
  logic             cmd_err;

  modport master (
    output cmd_valid, cmd_path, cmd_count,
    input  cmd_ready, done, hit_count, mismatch, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_path, cmd_count,
    output cmd_ready, done, hit_count, mismatch, cmd_err
  );

endinterface

// File: rtl/fsm_path_sequencer.sv
// Drives the 5-state branch FSM along a commanded path N times and checks its output.
// Legal command: done at accept+2+3N; illegal command: done at accept+1. cmd_ready is low while busy, and cmd_valid is ignored then.
module fsm_path_sequencer
  import fsm_seq_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  fsm_path_sequencer_if.slave  cmd,
  output logic                 fsm_rst_n,
  output logic                 fsm_x,
  output logic                 fsm_y,
  input  logic                 fsm_out
);

  seq_state_e       state_q;
  seq_state_e       state_d;
  path_e            path_q;
  logic [CNT_W-1:0] remaining_q;
  logic [CNT_W-1:0] remaining_dec;
  logic [CNT_W-1:0] hit_q;
  logic             mismatch_q;
  logic             cmd_err_q;
  logic             done_q;
  logic             fsm_rst_n_q;
  logic             accept;

  assign accept        = (state_q == ST_IDLE) && cmd.cmd_valid;
  assign remaining_dec = (remaining_q != '0) ? remaining_q - CNT_W'(1) : '0;

  always_comb begin
    state_d = state_q;
    fsm_x   = 1'b0;
    fsm_y   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          state_d = (path_e'(cmd.cmd_path) == PATH_ILLEGAL) ? ST_DONE : ST_SYNC;
        end
      end
      ST_SYNC:  state_d = (remaining_q != '0) ? ST_DRV_X : ST_DONE;
      ST_DRV_X: begin
        fsm_x   = (path_q != PATH_S2_S4);
        state_d = ST_DRV_Y;
      end
      ST_DRV_Y: begin
        fsm_y   = (path_q == PATH_S1_S3);
        state_d = ST_CHK;
      end
      // The FSM is back in s0 after CHK, so the next traversal starts straight away.
      ST_CHK:   state_d = (remaining_dec != '0) ? ST_DRV_X : ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      path_q      <= PATH_S2_S4;
      remaining_q <= '0;
      hit_q       <= '0;
      mismatch_q  <= 1'b0;
      cmd_err_q   <= 1'b0;
      done_q      <= 1'b0;
      fsm_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_q      <= (state_d == ST_DONE);
      fsm_rst_n_q <= (state_d != ST_SYNC);
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            path_q      <= path_e'(cmd.cmd_path);
            remaining_q <= cmd.cmd_count;
            hit_q       <= '0;
            mismatch_q  <= 1'b0;
            cmd_err_q   <= (path_e'(cmd.cmd_path) == PATH_ILLEGAL);
          end
        end
        // The FSM output must stay low until it reaches s3.
        ST_SYNC, ST_DRV_X, ST_DRV_Y: begin
          if (fsm_out) mismatch_q <= 1'b1;
        end
        ST_CHK: begin
          if (fsm_out) hit_q <= hit_q + CNT_W'(1);
          if (fsm_out != path_hits(path_q)) mismatch_q <= 1'b1;
          remaining_q <= remaining_dec;
        end
        default: ;
      endcase
    end
  end

  assign fsm_rst_n     = fsm_rst_n_q;
  assign cmd.cmd_ready = (state_q == ST_IDLE);
  assign cmd.done      = done_q;
  assign cmd.hit_count = hit_q;
  assign cmd.mismatch  = mismatch_q;
  assign cmd.cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_fsm_path_sequencer.sv
// Bench for fsm_path_sequencer with a behavioural branch FSM, directed cases and random commands.
// Expected results come from the path rules and cycle arithmetic.
module tb_fsm_path_sequencer;
  import fsm_seq_pkg::*;

  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst;
  logic fsm_rst_n;
  logic fsm_x;
  logic fsm_y;
  logic fsm_out;

  fsm_path_sequencer_if #(.CNT_W(CNT_W)) cif ();

  fsm_path_sequencer #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cif),
    .fsm_rst_n (fsm_rst_n),
    .fsm_x     (fsm_x),
    .fsm_y     (fsm_y),
    .fsm_out   (fsm_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Branch FSM model: s0 -x-> s1 / s2, s1 -y-> s3 / s4, s2 -> s4, s3/s4 -> s0; out high in s3.
  int fst = 0;
  always @(posedge clk) begin
    if (!fsm_rst_n) fst <= 0;
    else begin
      case (fst)
        0:       fst <= fsm_x ? 1 : 2;
        1:       fst <= fsm_y ? 3 : 4;
        2:       fst <= 4;
        default: fst <= 0;
      endcase
    end
  end

  int inj_cyc = -1;
  assign fsm_out = (fst == 3) || (cyc == inj_cyc);

  int n_checks = 0;
  int n_errors = 0;
  int t_acc    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic issue(input int path, input int cnt);
    int w = 0;
    @(negedge clk);
    while (!cif.cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check_eq("ready_before_accept", 32'(cif.cmd_ready), 1);
    cif.cmd_valid = 1'b1;
    cif.cmd_path  = path[1:0];
    cif.cmd_count = cnt[CNT_W-1:0];
    t_acc         = cyc;
  endtask

  // inj >= 0 forces fsm_out high in the cycle accept+inj.
  task automatic run_cmd(input int path, input int cnt, input int inj);
    bit legal    = (path != 3);
    int exp_done = legal ? 1 + SYNC_LAT + TRAV_LEN * cnt : 1;
    bit inj_chk  = (inj >= 2) && ((inj - 2) % TRAV_LEN == 2);
    int exp_hit  = ((path == 2) ? cnt : 0) + ((inj_chk && path != 2) ? 1 : 0);
    int exp_mm   = (inj >= 0 && !(inj_chk && path == 2)) ? 1 : 0;
    int bad      = 0;
    int rst_lo   = 0;
    int done_o   = -1;
    int o, r;
    bit in_trav, ex, ey;
    inj_cyc = -1;
    issue(path, cnt);
    if (inj >= 0) inj_cyc = t_acc + inj;
    for (int i = 0; i < exp_done + 10 && done_o < 0; i++) begin
      @(negedge clk);
      o = cyc - t_acc;
      if (o == 1) begin
        check_eq("hit_cleared", 32'(cif.hit_count), 0);
        check_eq("mismatch_cleared", 32'(cif.mismatch), 0);
        check_eq("cmd_err_at_start", 32'(cif.cmd_err), legal ? 0 : 1);
      end
      in_trav = legal && o >= 2 && o < 1 + SYNC_LAT + TRAV_LEN * cnt;
      r       = (o - 2) % TRAV_LEN;
      ex      = in_trav && r == 0 && path != 0;
      ey      = in_trav && r == 1 && path == 2;
      if (fsm_x !== ex || fsm_y !== ey || cif.cmd_ready !== 1'b0) bad++;
      if (fsm_rst_n !== 1'b1) rst_lo++;
      if (cif.done === 1'b1) begin
        done_o        = o;
        cif.cmd_valid = 1'b0;
      end else begin
        cif.cmd_valid = 1'($urandom);
        cif.cmd_path  = 2'($urandom);
        cif.cmd_count = CNT_W'($urandom);
      end
    end
    cif.cmd_valid = 1'b0;
    inj_cyc       = -1;
    check_eq("done_latency", done_o, exp_done);
    check_eq("hit_count", 32'(cif.hit_count), exp_hit);
    check_eq("mismatch", 32'(cif.mismatch), exp_mm);
    check_eq("cmd_err", 32'(cif.cmd_err), legal ? 0 : 1);
    check_eq("fsm_rst_pulses", rst_lo, legal ? 1 : 0);
    check_eq("slot_decode_bad_cycles", bad, 0);
    @(negedge clk);
    check_eq("ready_after_done", 32'(cif.cmd_ready), 1);
    check_eq("done_one_cycle", 32'(cif.done), 0);
    check_eq("hit_hold", 32'(cif.hit_count), exp_hit);
    check_eq("mismatch_hold", 32'(cif.mismatch), exp_mm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int spurious_done;
    rst           = 1'b1;
    cif.cmd_valid = 1'b0;
    cif.cmd_path  = 2'd0;
    cif.cmd_count = '0;

    @(negedge clk);
    @(negedge clk);
    check_eq("rst_ready", 32'(cif.cmd_ready), 1);
    check_eq("rst_fsm_rst_n", 32'(fsm_rst_n), 0);
    check_eq("rst_hit", 32'(cif.hit_count), 0);
    check_eq("rst_done", 32'(cif.done), 0);
    check_eq("rst_mismatch", 32'(cif.mismatch), 0);
    check_eq("rst_xy", 32'({fsm_x, fsm_y}), 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("fsm_rst_n_release", 32'(fsm_rst_n), 1);
    check_eq("idle_ready", 32'(cif.cmd_ready), 1);

    run_cmd(2, 3, -1);
    run_cmd(0, 4, -1);
    run_cmd(1, 2, -1);
    run_cmd(1, 0, -1);
    run_cmd(3, 5, -1);
    run_cmd(0, 2, 7);
    run_cmd(0, 1, -1);

    // Reset in the first DRV_Y of a long command.
    issue(2, 5);
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("mid_cmd_drv_y", 32'(fsm_y), 1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_ready", 32'(cif.cmd_ready), 1);
    check_eq("mid_rst_fsm_rst_n", 32'(fsm_rst_n), 0);
    check_eq("mid_rst_done", 32'(cif.done), 0);
    rst = 1'b0;
    spurious_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cif.done === 1'b1) spurious_done++;
    end
    check_eq("no_done_after_rst", spurious_done, 0);
    run_cmd(2, 1, -1);

    for (int i = 0; i < 20; i++) begin
      int p, c, inj;
      p   = $urandom_range(0, 3);
      c   = $urandom_range(0, 5);
      inj = -1;
      if (p != 3 && $urandom_range(0, 2) == 0) inj = $urandom_range(1, 1 + TRAV_LEN * c);
      run_cmd(p, c, inj);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
